mem_bist_ctrl: RTL

//  March C- built-in self-test controller sitting directly upstream of the MemGen_16_10 macro.

---
 rtl/mem_bist_pkg.sv | 47 ++++
 rtl/mem_bist_addr_gen.sv | 40 ++++
 rtl/mem_bist_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and March C- element table for the memory BIST controller.
//   march_elem_e : the six March C- elements E0..E5
//   bist_state_e : controller FSM states
//   elem_*()     : per-element direction, read/write background and op mix
package mem_bist_pkg;

    typedef enum logic [2:0] {
        E0, E1, E2, E3, E4, E5
    } march_elem_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_FIN
    } bist_state_e;

    // One bit per element, bit index = element number.
    // E0 up:W0  E1 up:R0,W1  E2 up:R1,W0  E3 down:R0,W1  E4 down:R1,W0  E5 down:R0
    localparam logic [5:0] ELEM_DOWN   = 6'b111000;
    localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [5:0] ELEM_RD_BG1 = 6'b010100;  // read expects all-ones
    localparam logic [5:0] ELEM_WR_BG1 = 6'b001010;  // write stores all-ones

    function automatic logic elem_down(input march_elem_e e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic elem_has_rd(input march_elem_e e);
        return ELEM_HAS_RD[e];
    endfunction

    function automatic logic elem_has_wr(input march_elem_e e);
        return ELEM_HAS_WR[e];
    endfunction

    function automatic logic elem_rd_bg(input march_elem_e e);
        return ELEM_RD_BG1[e];
    endfunction

    function automatic logic elem_wr_bg(input march_elem_e e);
        return ELEM_WR_BG1[e];
    endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down address counter for the March sequencer.
//   clock, reset : single clock, synchronous active-high reset
//   load         : start a new element; load_down selects direction
//                  (up starts at 0, down starts at all-ones)
//   step         : advance one address in the loaded direction
//   addr         : current address
//   first, last  : current address is the first / last of the element
module mem_bist_addr_gen #(
    parameter int AW = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          first,
    output logic          last
);

    logic down;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            down <= load_down;
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? addr - AW'(1) : addr + AW'(1);
        end
    end

    always_comb begin
        first = down ? (addr == '1) : (addr == '0);
        last  = down ? (addr == '0) : (addr == '1);
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST controller in front of the MemGen_16_10 macro.
// While idle the functional port passes straight through to the macro;
// while busy the BIST sequencer owns the macro and checks rd_data.
//   clock, reset        : single clock, synchronous active-high reset
//   start               : 1-cycle pulse, accepted only when idle
//   busy, done, pass    : run status (done/pass sticky until next start)
//   func_*              : functional macro request
//   mem_*               : macro interface (mem_rd_data from the macro)
//   fail_addr/fail_data : first mismatch, present only when the
//                         MEM_BIST_FAIL_LOG_EN macro is defined
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    input  logic          func_chip_en,
    input  logic          func_wr_en,
    input  logic          func_rd_en,
    input  logic [AW-1:0] func_addr,
    input  logic [DW-1:0] func_wr_data,
    output logic          mem_chip_en,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data
`ifdef MEM_BIST_FAIL_LOG_EN
    ,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
`endif
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    bist_state_e    state;
    march_elem_e    elem;
    march_elem_e    elem_next;
    march_elem_e    enter_elem;
    logic           fail_flag;
    logic [WCW-1:0] wait_cnt;

    logic           bist_chip_en;
    logic           bist_wr_en;
    logic           bist_rd_en;
    logic [DW-1:0]  bist_wr_data;

    logic [AW-1:0]  ag_addr;
    logic           ag_first;
    logic           ag_last;
    logic           ag_load;
    logic           ag_load_down;
    logic           ag_step;

    logic           wait_last;
    logic           addr_done;
    logic           run_end;
    logic           issue;
    logic           mismatch;
    logic [DW-1:0]  rd_expect;

    mem_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .first     (ag_first),
        .last      (ag_last)
    );

    // The NEXT_ADDR / NEXT_ELEM decisions are folded into the final cycle
    // of each address so no extra cycles are spent between addresses.
    always_comb begin
        wait_last    = (wait_cnt == WCW'(RD_LAT - 1));
        addr_done    = (state == ST_WR) ||
                       (state == ST_WAIT && wait_last && !elem_has_wr(elem));
        run_end      = addr_done && ag_last && (elem == E5);
        elem_next    = (elem == E5) ? E5 : march_elem_e'(elem + 3'd1);
        enter_elem   = (state == ST_IDLE) ? E0 : (ag_last ? elem_next : elem);
        issue        = (state == ST_IDLE && start) || (addr_done && !run_end);
        ag_load      = (state == ST_IDLE && start) ||
                       (addr_done && ag_last && elem != E5);
        ag_load_down = elem_down(enter_elem);
        ag_step      = addr_done && !ag_last;
        rd_expect    = {DW{elem_rd_bg(elem)}};
        mismatch     = (mem_rd_data != rd_expect);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            elem         <= E0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_flag    <= 1'b0;
            wait_cnt     <= '0;
            bist_chip_en <= 1'b0;
            bist_wr_en   <= 1'b0;
            bist_rd_en   <= 1'b0;
            bist_wr_data <= '0;
`ifdef MEM_BIST_FAIL_LOG_EN
            fail_addr    <= '0;
            fail_data    <= '0;
`endif
        end else begin
            bist_chip_en <= 1'b0;
            bist_wr_en   <= 1'b0;
            bist_rd_en   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_flag <= 1'b0;
`ifdef MEM_BIST_FAIL_LOG_EN
                        fail_addr <= '0;
                        fail_data <= '0;
`endif
                    end
                end
                ST_RD: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!wait_last) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end else begin
                        if (mismatch) begin
                            fail_flag <= 1'b1;
`ifdef MEM_BIST_FAIL_LOG_EN
                            if (!fail_flag) begin
                                fail_addr <= ag_addr;
                                fail_data <= mem_rd_data;
                            end
`endif
                        end
                        if (elem_has_wr(elem)) begin
                            state        <= ST_WR;
                            bist_chip_en <= 1'b1;
                            bist_wr_en   <= 1'b1;
                            bist_wr_data <= {DW{elem_wr_bg(elem)}};
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= ~fail_flag;
                end
                default: ;
            endcase

            if (run_end) begin
                state <= ST_FIN;
            end

            // First op of the next address (or of the next element).
            if (issue) begin
                state        <= elem_has_rd(enter_elem) ? ST_RD : ST_WR;
                elem         <= enter_elem;
                bist_chip_en <= 1'b1;
                bist_rd_en   <= elem_has_rd(enter_elem);
                bist_wr_en   <= !elem_has_rd(enter_elem);
                bist_wr_data <= {DW{elem_wr_bg(enter_elem)}};
            end
        end
    end

    always_comb begin
        mem_chip_en = busy ? bist_chip_en : func_chip_en;
        mem_wr_en   = busy ? bist_wr_en   : func_wr_en;
        mem_rd_en   = busy ? bist_rd_en   : func_rd_en;
        mem_addr    = busy ? ag_addr      : func_addr;
        mem_wr_data = busy ? bist_wr_data : func_wr_data;
    end

    // Every element load must land on the element's first address.
    a_load_first : assert property (@(posedge clock) disable iff (reset)
                                    ag_load |=> ag_first);

endmodule
